// File: rtl/generic_bus_ram_responder.sv
// Word-organised RAM responder for the generic bus: programmable wait states,
// byte-lane writes, busy handshake. Optional range checking via BUS_RESP_ERR_EN.
module generic_bus_ram_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic        wen,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        busy
`ifdef BUS_RESP_ERR_EN
    ,
    output logic        error
`endif
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]    state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          req;
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          in_range;
    logic          done_xfer;
    logic          write_go;
    logic          read_go;
    logic [31:0]   rd_word;
    logic          unused_bits;

    assign req         = ren | wen;
    assign offset      = addr - BASE_ADDR;
    assign index       = offset[AW+1:2];
    assign unused_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef BUS_RESP_ERR_EN
    // offset bits above the window must be zero; the compare against BASE_ADDR catches wrap-around
    assign in_range = (addr >= BASE_ADDR) && (offset[31:AW+2] == '0);
`else
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Reset masks the completion cycle so a write caught by RST is dropped.
    assign done_xfer = (state_reg == DONE) && req && !RST;
    assign write_go  = done_xfer && wen && in_range;
    assign read_go   = done_xfer && ren && !wen && in_range;
    assign busy      = req && !done_xfer;
    assign rdata     = read_go ? rd_word : 32'h0;

`ifdef BUS_RESP_ERR_EN
    assign error = done_xfer && !in_range;
`endif

    // One RAM per byte lane. addr is held through the transfer, so the read
    // register always holds the addressed word by the time DONE is reached.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge CLK) begin
                if (write_go && byte_en[gi]) begin
                    lane_mem[index] <= wdata[8*gi +: 8];
                end
                lane_rd_reg <= lane_mem[index];
            end

            assign rd_word[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: unit 0 uses WAIT_CYCLES=2, unit 1 uses
// WAIT_CYCLES=0. Range-check tests follow BUS_RESP_ERR_EN.
module tb_generic_bus_ram_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_s [2];
    logic        ren_s   [2];
    logic        wen_s   [2];
    logic        busy_s  [2];
    logic [3:0]  be_s    [2];
`ifdef BUS_RESP_ERR_EN
    logic        err_s   [2];
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    generic_bus_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(BASE)) dut (
        .CLK(clk), .RST(rst), .addr(addr_s[0]), .wdata(wdata_s[0]), .ren(ren_s[0]),
        .wen(wen_s[0]), .byte_en(be_s[0]), .rdata(rdata_s[0]), .busy(busy_s[0])
`ifdef BUS_RESP_ERR_EN
        , .error(err_s[0])
`endif
    );

    generic_bus_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
        .CLK(clk), .RST(rst), .addr(addr_s[1]), .wdata(wdata_s[1]), .ren(ren_s[1]),
        .wen(wen_s[1]), .byte_en(be_s[1]), .rdata(rdata_s[1]), .busy(busy_s[1])
`ifdef BUS_RESP_ERR_EN
        , .error(err_s[1])
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // ph = cycles the current request has been held since its transfer began;
    // the transfer completes in the cycle where ph == wait cycles + 1.
    int          ph [2];
    logic [31:0] mm [2][DEPTH];
    bit          kn [2][DEPTH];

    function automatic int wc(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
`ifdef BUS_RESP_ERR_EN
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + DEPTH * 4);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst || !(ren_s[u] || wen_s[u])) begin
                ph[u] <= 0;
            end else if (ph[u] == wc(u) + 1) begin
                if (wen_s[u] && in_rng(addr_s[u])) begin
                    mm[u][widx(addr_s[u])] <= merge(mm[u][widx(addr_s[u])], wdata_s[u], be_s[u]);
                    kn[u][widx(addr_s[u])] <= kn[u][widx(addr_s[u])] || (be_s[u] == 4'hF);
                end
                ph[u] <= 0;
            end else begin
                ph[u] <= ph[u] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic        rq, dn, rd_cyc;
            logic [31:0] exp_rd;
            rq     = ren_s[u] || wen_s[u];
            dn     = !rst && rq && (ph[u] == wc(u) + 1);
            rd_cyc = dn && ren_s[u] && !wen_s[u] && in_rng(addr_s[u]);
            chk($sformatf("busy[%0d]", u), {31'b0, busy_s[u]}, {31'b0, rq && !dn});
            exp_rd = rd_cyc ? mm[u][widx(addr_s[u])] : 32'h0;
            if (!(rd_cyc && !kn[u][widx(addr_s[u])]))
                chk($sformatf("rdata[%0d]", u), rdata_s[u], exp_rd);
`ifdef BUS_RESP_ERR_EN
            chk($sformatf("error[%0d]", u), {31'b0, err_s[u]}, {31'b0, dn && !in_rng(addr_s[u])});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 = read, 1 = write, 2 = read+write; returns completion data and busy length
    task automatic xfer(input int u, input int mode, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output int nb, output logic er);
        bit done;
        addr_s[u]  = a;
        wdata_s[u] = d;
        be_s[u]    = be;
        ren_s[u]   = (mode != 1);
        wen_s[u]   = (mode != 0);
        nb = 0; rd = 32'h0; er = 1'b0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy_s[u]) nb++;
            else begin
                done = 1;
                rd   = rdata_s[u];
`ifdef BUS_RESP_ERR_EN
                er   = err_s[u];
`endif
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL timeout[%0d]: busy never dropped at addr %h", u, a);
        end
        tick();
        ren_s[u] = 1'b0;
        wen_s[u] = 1'b0;
    endtask

    logic [31:0] rd;
    int          nb;
    logic        er;

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            addr_s[u] = 32'h0; wdata_s[u] = 32'h0; be_s[u] = 4'h0;
            ren_s[u] = 1'b0; wen_s[u] = 1'b0;
        end
        tick(); tick();
        @(negedge clk);
        chk("reset_busy", {31'b0, busy_s[0]}, 32'd0);
        chk("reset_rdata", rdata_s[0], 32'h0);
        tick();
        ren_s[0] = 1'b1;
        @(negedge clk);
        chk("reset_busy_req", {31'b0, busy_s[0]}, 32'd1);
        tick();
        ren_s[0] = 1'b0;
        rst = 1'b0;
        tick();

        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, nb, er);
        $display("write 0x10 <= DEADBEEF busy=%0d", nb);
        chk("wr_busy_len", nb, 32'd3);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, nb, er);
        $display("read  0x10 -> %h busy=%0d", rd, nb);
        chk("rd_full", rd, 32'hDEADBEEF);
        chk("rd_busy_len", nb, 32'd3);
        @(negedge clk);
        chk("rd_after_done", rdata_s[0], 32'h0);
        tick();

        xfer(0, 1, 32'h10, 32'h0000AA00, 4'b0010, rd, nb, er);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, nb, er);
        $display("lane write then read 0x10 -> %h", rd);
        chk("rd_lane", rd, 32'hDEADAAEF);

        xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, nb, er);
        xfer(0, 0, 32'h13, 32'h0, 4'h0, rd, nb, er);
        $display("be=0 write then read 0x13 -> %h", rd);
        chk("rd_be0_lowbits", rd, 32'hDEADAAEF);

        // abort: write dropped after one cycle in WAIT
        xfer(0, 1, 32'h20, 32'h11111111, 4'hF, rd, nb, er);
        addr_s[0] = 32'h20; wdata_s[0] = 32'h22222222; be_s[0] = 4'hF; wen_s[0] = 1'b1;
        tick();
        wen_s[0] = 1'b0;
        tick();
        xfer(0, 0, 32'h20, 32'h0, 4'h0, rd, nb, er);
        $display("abort then read 0x20 -> %h busy=%0d", rd, nb);
        chk("rd_abort", rd, 32'h11111111);
        chk("abort_restart_len", nb, 32'd3);

        // reset during WAIT discards the write
        xfer(0, 1, 32'h30, 32'h33333333, 4'hF, rd, nb, er);
        addr_s[0] = 32'h30; wdata_s[0] = 32'h44444444; wen_s[0] = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_busy", {31'b0, busy_s[0]}, 32'd1);
        tick(); tick();
        rst = 1'b0;
        wen_s[0] = 1'b0;
        tick();
        xfer(0, 0, 32'h30, 32'h0, 4'h0, rd, nb, er);
        $display("reset-in-wait then read 0x30 -> %h busy=%0d", rd, nb);
        chk("rd_rst_abort", rd, 32'h33333333);
        chk("rst_restart_len", nb, 32'd3);

        xfer(0, 2, 32'h40, 32'hCAFEF00D, 4'hF, rd, nb, er);
        $display("ren+wen 0x40 -> rdata %h", rd);
        chk("rw_rdata_zero", rd, 32'h0);
        xfer(0, 0, 32'h40, 32'h0, 4'h0, rd, nb, er);
        $display("read 0x40 -> %h", rd);
        chk("rw_wrote", rd, 32'hCAFEF00D);

        xfer(0, 1, 32'h0, 32'h01020304, 4'hF, rd, nb, er);
`ifdef BUS_RESP_ERR_EN
        xfer(0, 0, 32'h400, 32'h0, 4'h0, rd, nb, er);
        $display("read 0x400 -> %h error=%0b", rd, er);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_error", {31'b0, er}, 32'd1);
        xfer(0, 1, 32'h400, 32'hA5A5A5A5, 4'hF, rd, nb, er);
        xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, nb, er);
        $display("oor write then read 0x0 -> %h error=%0b", rd, er);
        chk("oor_no_write", rd, 32'h01020304);
        chk("inrange_error", {31'b0, er}, 32'd0);
`else
        xfer(0, 1, 32'h400, 32'hA5A5A5A5, 4'hF, rd, nb, er);
        xfer(0, 0, 32'h0, 32'h0, 4'h0, rd, nb, er);
        $display("alias write 0x400 then read 0x0 -> %h", rd);
        chk("alias_write", rd, 32'hA5A5A5A5);
`endif

        // zero-wait unit
        xfer(1, 1, 32'h8, 32'h12345678, 4'hF, rd, nb, er);
        $display("w0 write 0x8 busy=%0d", nb);
        chk("w0_wr_len", nb, 32'd1);
        xfer(1, 0, 32'h8, 32'h0, 4'h0, rd, nb, er);
        $display("w0 read 0x8 -> %h busy=%0d", rd, nb);
        chk("w0_rd", rd, 32'h12345678);
        addr_s[1] = 32'h8; ren_s[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            $display("w0 held read cycle %0d busy=%0b rdata=%h", i, busy_s[1], rdata_s[1]);
            chk($sformatf("b2b_busy%0d", i), {31'b0, busy_s[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        ren_s[1] = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
